// File: rtl/text_overlay_ctrl.sv
// rtl/text_overlay_ctrl.sv - end-of-game text overlay sequencer
// Owns the character buffer write port; every write and overlay edge lands in vertical blanking.
module text_overlay_ctrl #(
  parameter int         MSG_COL    = 2,
  parameter int         MSG_ROW    = 7,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblnk,
  input  logic       endgame,
  input  logic       endgame2,
  input  logic       restart,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       overlay_en,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_WRITE,
    S_SHOW,
    S_HIDE
  } state_t;

  localparam logic [1:0] MSG_P1   = 2'd0;
  localparam logic [1:0] MSG_P2   = 2'd1;
  localparam logic [1:0] MSG_DRAW = 2'd2;

  localparam logic [7:0] LAST_CLEAR = 8'd255;
  localparam logic [7:0] LAST_CHAR  = 8'd12;
  localparam logic [3:0] COL0       = 4'(MSG_COL);
  localparam logic [3:0] ROW        = 4'(MSG_ROW);

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic       armed_q, armed_d;
  logic [1:0] msg_q, msg_d;

  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       overlay_q, overlay_d;
  logic       busy_q, busy_d;

  // 13-character message table; the player digit is the only difference between the win texts
  function automatic logic [7:0] msg_char(input logic [1:0] sel, input logic [3:0] k);
    logic [7:0] c;
    c = 8'h20;
    if (sel == MSG_DRAW) begin
      case (k)
        4'd4:    c = "D";
        4'd5:    c = "R";
        4'd6:    c = "A";
        4'd7:    c = "W";
        default: c = 8'h20;
      endcase
    end else begin
      case (k)
        4'd0:    c = "P";
        4'd1:    c = "L";
        4'd2:    c = "A";
        4'd3:    c = "Y";
        4'd4:    c = "E";
        4'd5:    c = "R";
        4'd7:    c = (sel == MSG_P2) ? "2" : "1";
        4'd9:    c = "W";
        4'd10:   c = "I";
        4'd11:   c = "N";
        4'd12:   c = "S";
        default: c = 8'h20;
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      idx_q     <= 8'd0;
      armed_q   <= 1'b0;
      msg_q     <= MSG_P1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
      overlay_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      armed_q   <= armed_d;
      msg_q     <= msg_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      overlay_q <= overlay_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    msg_d   = msg_q;
    case (state_q)
      S_CLEAR: begin
        if (vblnk) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == LAST_CLEAR) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        // Arming requires both inputs seen low, so a level still held from the last game cannot retrigger
        if (!endgame && !endgame2) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          if (endgame && endgame2) msg_d = MSG_DRAW;
          else if (endgame)        msg_d = MSG_P1;
          else                     msg_d = MSG_P2;
          armed_d = 1'b0;
          idx_d   = 8'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (vblnk) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == LAST_CHAR) state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (!endgame && !endgame2) armed_d = 1'b1;
        if (restart) state_d = S_HIDE;
      end
      S_HIDE: begin
        if (vblnk) begin
          idx_d   = 8'd0;
          state_d = S_CLEAR;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    overlay_d = overlay_q;
    busy_d    = (state_d == S_CLEAR) || (state_d == S_WRITE) || (state_d == S_HIDE);
    case (state_q)
      S_CLEAR: begin
        if (vblnk) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = BLANK_CHAR;
        end
      end
      S_WRITE: begin
        if (vblnk) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {COL0 + idx_q[3:0], ROW};
          wr_data_d = msg_char(msg_q, idx_q[3:0]);
        end
      end
      S_SHOW: begin
        if (vblnk) overlay_d = 1'b1;
      end
      S_HIDE: begin
        if (vblnk) overlay_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign overlay_en = overlay_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// tb/tb_text_overlay_ctrl.sv - scoreboard bench for text_overlay_ctrl
// Expected buffer writes are queued by the stimulus; a negedge monitor pops and compares them.
module tb_text_overlay_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       endgame = 1'b0;
  logic       endgame2 = 1'b0;
  logic       restart = 1'b0;
  logic       vbl_auto = 1'b1;
  logic       vbl_man = 1'b0;
  logic       vbl_tog = 1'b0;
  logic       vblnk;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       overlay_en;
  logic       busy;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_writes = 0;
  logic [15:0] exp_q[$];
  logic        vbl_at_edge = 1'b0;
  logic        prev_ov = 1'b0;

  assign vblnk = vbl_auto ? vbl_tog : vbl_man;

  text_overlay_ctrl #(
    .MSG_COL   (2),
    .MSG_ROW   (7),
    .BLANK_CHAR(8'h20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vblnk     (vblnk),
    .endgame   (endgame),
    .endgame2  (endgame2),
    .restart   (restart),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .overlay_en(overlay_en),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 100) begin
        cnt = 0;
        vbl_tog = ~vbl_tog;
      end
    end
  end

  always @(posedge clk) vbl_at_edge <= vblnk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        n_writes++;
        chk("write_in_vblank", 32'(vbl_at_edge), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr_data", 32'({wr_addr, wr_data}), 32'(e));
        end
      end
      if (rst_n && (overlay_en !== prev_ov)) chk("overlay_edge_in_vblank", 32'(vbl_at_edge), 32'd1);
      prev_ov = overlay_en;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 8'h20});
  endtask

  task automatic push_msg(input string s);
    for (int k = 0; k < 13; k++) exp_q.push_back({4'(2 + k), 4'd7, s[k]});
  endtask

  task automatic wait_busy_low(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      cycles(1);
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_overlay(input int budget, input string name);
    int n;
    n = 0;
    while (overlay_en !== 1'b1 && n < budget) begin
      cycles(1);
      n++;
    end
    chk(name, 32'(overlay_en), 32'd1);
  endtask

  task automatic wait_writes(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (n_writes < target && n < budget) begin
      cycles(1);
      n++;
    end
    chk(name, 32'(n_writes), 32'(target));
  endtask

  initial begin
    cycles(3);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_overlay", 32'(overlay_en), 32'd0);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_addr_data", 32'({wr_addr, wr_data}), 32'd0);

    push_clear();
    rst_n = 1'b1;
    wait_busy_low(2000, "reset_clear_done");
    chk("reset_clear_drained", 32'(exp_q.size()), 32'd0);
    chk("reset_clear_count", 32'(n_writes), 32'd256);

    vbl_auto = 1'b0;
    vbl_man  = 1'b1;
    cycles(3);
    endgame = 1'b1;
    push_msg("PLAYER 1 WINS");
    wait_writes(261, 50, "p1_first_five");
    vbl_man = 1'b0;
    cycles(20);
    chk("stall_no_writes", 32'(n_writes), 32'd261);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_no_overlay", 32'(overlay_en), 32'd0);
    vbl_man = 1'b1;
    wait_overlay(100, "p1_overlay_rise");
    chk("p1_drained", 32'(exp_q.size()), 32'd0);
    chk("p1_write_count", 32'(n_writes), 32'd269);
    chk("show_not_busy", 32'(busy), 32'd0);

    vbl_man = 1'b0;
    cycles(2);
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    cycles(10);
    chk("hide_waits_vblank", 32'(overlay_en), 32'd1);
    chk("hide_busy", 32'(busy), 32'd1);
    push_clear();
    vbl_man = 1'b1;
    wait_busy_low(400, "restart_clear_done");
    chk("restart_overlay_off", 32'(overlay_en), 32'd0);
    chk("restart_clear_drained", 32'(exp_q.size()), 32'd0);

    cycles(20);
    chk("no_retrigger_busy", 32'(busy), 32'd0);
    chk("no_retrigger_writes", 32'(n_writes), 32'd525);

    endgame = 1'b0;
    cycles(2);
    endgame  = 1'b1;
    endgame2 = 1'b1;
    push_msg("    DRAW     ");
    wait_overlay(100, "draw_overlay_rise");
    chk("draw_drained", 32'(exp_q.size()), 32'd0);

    endgame  = 1'b0;
    endgame2 = 1'b0;
    cycles(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_overlay", 32'(overlay_en), 32'd0);
    chk("async_reset_busy", 32'(busy), 32'd1);
    chk("async_reset_wr_en", 32'(wr_en), 32'd0);
    push_clear();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    wait_busy_low(400, "post_reset_clear_done");
    chk("post_reset_clear_drained", 32'(exp_q.size()), 32'd0);

    cycles(3);
    endgame2 = 1'b1;
    push_msg("PLAYER 2 WINS");
    wait_overlay(100, "p2_overlay_rise");
    chk("p2_drained", 32'(exp_q.size()), 32'd0);
    endgame2 = 1'b0;
    cycles(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/text_overlay_ctrl.md
# text_overlay_ctrl

Sequencer for the end-of-game text overlay. It owns the write port of the 16x16 character buffer that the character renderer reads through `char_xy`, and clears that buffer after reset. When the game ends it writes the result message into the buffer, then raises `overlay_en`, which gates the renderer. All buffer writes and all `overlay_en` edges happen only during vertical blanking, so no frame ever shows a partial message.

## Interface

Parameters:
- `MSG_COL`, default 2: first column of the message (0..3, so 13 characters fit in 16 columns).
- `MSG_ROW`, default 7: row of the message (0..15).
- `BLANK_CHAR`, default 8'h20: code written by a clear.

Ports:
- `clk`, input, 1: pixel clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `vblnk`, input, 1: vertical blanking from the timing chain.
- `endgame`, input, 1: player 1 has won (level).
- `endgame2`, input, 1: player 2 has won (level).
- `restart`, input, 1: one-cycle pulse that dismisses the message.
- `wr_en`, output, 1: character buffer write strobe.
- `wr_addr`, output, 8: `{col[3:0], row[3:0]}`, the same packing as `char_xy`.
- `wr_data`, output, 8: character code (ASCII).
- `overlay_en`, output, 1: enables the renderer.
- `busy`, output, 1: high whenever the FSM is not in IDLE or SHOW.

## Operation

FSM states are CLEAR, IDLE, WRITE, SHOW and HIDE. All outputs are registered.

**CLEAR**
- An 8-bit counter `idx` runs from 0 to 255.
- On each cycle with `vblnk`=1: `wr_en`=1, `wr_addr`=`idx`, `wr_data`=`BLANK_CHAR`, then `idx`++.
- On cycles with `vblnk`=0: `wr_en`=0 and `idx` holds (the clear pauses and resumes).
- The write with `idx`=255 exits to IDLE.

**IDLE**
- An `armed` flag is set once `endgame`=0 and `endgame2`=0 have been sampled together.
- When `armed`=1 and (`endgame` or `endgame2`) is high, the message is latched:
  - `endgame` only: "PLAYER 1 WINS"
  - `endgame2` only: "PLAYER 2 WINS"
  - both high on the same cycle: "    DRAW     " (13 characters, space padded)
- `armed` clears, `idx` is set to 0, and the FSM goes to WRITE.

**WRITE**
- 13 characters from an internal constant table, stalled by `vblnk` exactly like CLEAR.
- Write k (0..12) uses `wr_addr` = `{MSG_COL+k, MSG_ROW}` and `wr_data` = character k.
- After write 12 the FSM goes to SHOW.
- `endgame`, `endgame2` and `restart` are ignored while in WRITE.

**SHOW**
- `overlay_en` is set on the first SHOW cycle with `vblnk`=1.
- A `restart` pulse is latched, even if `overlay_en` is not yet high, and moves the FSM to HIDE.
- `endgame`/`endgame2` are ignored, but `armed` tracking continues.

**HIDE**
- `overlay_en` clears on the first cycle with `vblnk`=1.
- On that same cycle the FSM goes to CLEAR with `idx`=0.
- CLEAR rewrites the whole buffer, then returns to IDLE.

**Outputs**
- `wr_en` is 0 in IDLE, SHOW and HIDE.
- `restart` is ignored in CLEAR and IDLE.

**Reset**
- `rst_n`=0 forces: state=CLEAR, `idx`=0, `armed`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `overlay_en`=0, `busy`=1.
- This applies at any time, including mid-WRITE or mid-SHOW. The overlay drops immediately, asynchronously.

## Timing

- Write throughput: one buffer write per `clk` cycle while `vblnk`=1. There are no bubbles inside blanking.
- Full clear: exactly 256 cycles with `vblnk`=1.
- Message: exactly 13 cycles with `vblnk`=1.
- Trigger latency: `endgame` sampled high in IDLE leads to state WRITE on the next edge. The first `wr_en` appears on the edge after that, if `vblnk`=1.
- `wr_en`, `wr_addr` and `wr_data` change together on the same edge. The buffer captures them on the following edge.
- `overlay_en` edges always coincide with a cycle where `vblnk`=1. They never occur during active video.
- `busy` is registered and equals (state ∈ {CLEAR, WRITE, HIDE}).
- `vblnk` falling mid-sequence: the current write completes, the next write waits, and no address is skipped or repeated.

## Test plan

- **Reset clear.** Release `rst_n` with `vblnk` toggling every 100 cycles. Require 256 writes of 8'h20 to addresses 0..255 in order, none while `vblnk`=0, and `busy` falling after address 255.
- **Player 1 win.** `endgame`=1 in IDLE (`MSG_COL`=2, `MSG_ROW`=7). Require writes 'P' to 8'h27, 'L' to 8'h37, … 'S' to 8'hE7. Require `overlay_en` to rise on a `vblnk`=1 cycle after the last write.
- **Simultaneous win.** `endgame`=`endgame2`=1 on the same cycle. Require the 13-character "    DRAW     " sequence, with 'D' written to address 8'h67.
- **Blanking stall.** Drop `vblnk` after the 5th WRITE character. Require `wr_en`=0 until `vblnk` returns, then resumption at character 5 (address 8'h77).
- **Restart and re-arm.**
  - `restart` pulse in SHOW with `endgame` still high: `overlay_en` falls on the next `vblnk`=1 cycle, then a full 256-write clear runs.
  - No new message until `endgame` is seen low and then high again.
- **Async reset mid-SHOW.** Assert `rst_n`=0 while `overlay_en`=1. Require `overlay_en`=0 with no clock edge, then a full clear after release.
